riscv_mc_control: RTL and testbench
===================================

// Module: riscv_mc_control
// PURPOSE
//  Multicycle control unit driving the single-cycle RV32I datapath's control inputs.
//  Decodes instr and Zero, sequences each instruction through IF/ID/EX/MEM/WB, and generates
//  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC. Also owns the data-memory
//  request/acknowledge handshake. Sits beside the datapath in the processor top level.
// PARAMETERS
//  MEM_TIMEOUT  16  max MEM-state cycles waiting for dAck before abort (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  instr      in   32  current instruction word (stable while PC is unchanged)
//  Zero       in   1   ALU zero flag from datapath
//  dAck       in   1   data memory done; level, sampled in MEM
//  PCSrc      out  1   1 = PC <= PC + B-imm, 0 = PC <= PC + 4
//  ALUSrc     out  1   1 = immediate operand, 0 = rs2
//  RegWrite   out  1   register file write strobe
//  MemToReg   out  1   1 = writeback from dReadData
//  ALUCtrl    out  4   ALU operation
//  loadPC     out  1   PC update strobe
//  MemRead    out  1   data memory read request
//  MemWrite   out  1   data memory write request
//  memTimeout out  1   one-cycle pulse: memory access aborted
//  illegal    out  1   one-cycle pulse: unsupported instruction retired as NOP
//  state      out  3   IF=0, ID=1, EX=2, MEM=3, WB=4 (debug)
// BEHAVIOUR
//  - Reset: state=IF, wait counter=0. RegWrite, loadPC, MemRead, MemWrite, memTimeout and
//    illegal are 0 immediately; no glitch on async assert. Mid-instruction reset aborts it.
//  - Supported instructions:
//    - R (0110011): add/sub (instr[30]), sll, slt, sltu, xor, srl/sra, or, and.
//    - I (0010011): addi, slli, slti, sltiu, xori, srli/srai, ori, andi.
//    - LW (0000011, f3=010), SW (0100011, f3=010), BEQ (1100011, f3=000).
//    - Any other opcode/funct3 is illegal.
//  - ALUCtrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001,
//    SRA 1010, SLTU 1011, XOR 1101. LW/SW use ADD; BEQ uses SUB; illegal uses ADD.
//  - ALUCtrl, ALUSrc and MemToReg are combinational decodes of instr, valid in every state.
//    - ALUSrc=1 for I/LW/SW.
//    - MemToReg=1 for LW only.
//  - PCSrc = isBEQ & Zero, combinational; only meaningful while loadPC=1.
//  - FSM, one state per cycle:
//    - IF -> ID -> EX.
//    - ID -> WB directly if illegal; EX is skipped.
//    - EX -> MEM for LW/SW; EX -> WB otherwise.
//    - MEM: MemRead (LW) or MemWrite (SW) held high. Wait counter increments each MEM cycle.
//      - dAck=1: go to WB and clear the counter.
//      - Counter reaches MEM_TIMEOUT-1 with dAck=0: go to WB flagged aborted, pulse
//        memTimeout in that WB.
//    - WB: loadPC=1 for exactly 1 cycle, then -> IF.
//      - RegWrite=1 for R, I and non-aborted LW.
//      - illegal=1 if the instruction is illegal.
//  - Strobes are never high outside the stated states. MemRead/MemWrite are never both high.
//  - dAck outside MEM is ignored. dAck in the same cycle as the timeout limit counts as success.
//  - Writes with rd=x0 still assert RegWrite; the register file discards them.
//  - Latency (IF to next IF):
//    - R/I/BEQ: 4 cycles.
//    - LW/SW: 5 + wait cycles (max 4 + MEM_TIMEOUT).
//    - Illegal: 3 cycles.
// TESTING
//  1. rst pulse mid-EX -> state=IF asynchronously, all strobes 0; next instr starts cleanly.
//  2. ADD x3,x1,x2 (0x002081B3) -> states 0,1,2,4; in WB: RegWrite=1, loadPC=1, PCSrc=0,
//     ALUCtrl=0010. SUB (0x402081B3) -> ALUCtrl=0110.
//  3. ADDI x1,x0,5 (0x00500093) -> ALUSrc=1, ALUCtrl=0010, RegWrite in WB, 4-cycle latency.
//  4. LW x5,8(x1) (0x0080A283), dAck after 3 cycles -> MemRead high 3 MEM cycles;
//     WB: MemToReg=1, RegWrite=1. SW x5,12(x1) (0x0050A623), dAck=1 immediately ->
//     MemWrite 1 cycle, RegWrite=0.
//  5. BEQ x1,x2,+8 (0x00208463) with Zero=1 -> WB PCSrc=1, loadPC=1; Zero=0 -> PCSrc=0;
//     RegWrite=0 in both cases.
//  6. LW with dAck held 0, MEM_TIMEOUT=16 -> 16 MEM cycles; WB memTimeout=1, RegWrite=0,
//     loadPC=1. Opcode 0x7F -> IF, ID, WB with illegal=1 and no writes.

Source files
------------

// File: rtl/riscv_mc_control_if.sv
// Control-unit <-> datapath/data-memory bundle; master is the control unit.
interface riscv_mc_control_if;
  logic [31:0] instr;
  logic        Zero;
  logic        dAck;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic        memTimeout;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  instr, Zero, dAck,
    output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
           MemRead, MemWrite, memTimeout, illegal, state
  );

  modport slave (
    output instr, Zero, dAck,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
           MemRead, MemWrite, memTimeout, illegal, state
  );
endinterface

// File: rtl/riscv_mc_control.sv
// Multicycle RV32I control: IF/ID/EX/MEM/WB sequencer plus combinational operand/ALU decode.
// 3..4 cycles per instruction, LW/SW wait in MEM for dAck up to MEM_TIMEOUT cycles.
module riscv_mc_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mc_control_if.master    bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_abort, w_abort_nxt;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_alt;
  logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_illegal;
  logic [3:0] w_alu_ctrl;
  logic       w_unused;

  assign w_opcode  = bus.instr[6:0];
  assign w_f3      = bus.instr[14:12];
  assign w_alt     = bus.instr[30];
  assign w_unused  = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  assign w_is_r    = (w_opcode == 7'b0110011);
  assign w_is_i    = (w_opcode == 7'b0010011);
  assign w_is_lw   = (w_opcode == 7'b0000011) && (w_f3 == 3'b010);
  assign w_is_sw   = (w_opcode == 7'b0100011) && (w_f3 == 3'b010);
  assign w_is_beq  = (w_opcode == 7'b1100011) && (w_f3 == 3'b000);
  assign w_illegal = !(w_is_r || w_is_i || w_is_lw || w_is_sw || w_is_beq);

  // instr[30] selects SUB only for R-type; for immediates it is part of the constant except on shifts
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    if (w_is_r || w_is_i) begin
      case (w_f3)
        3'b000:  w_alu_ctrl = (w_is_r && w_alt) ? ALU_SUB : ALU_ADD;
        3'b001:  w_alu_ctrl = ALU_SLL;
        3'b010:  w_alu_ctrl = ALU_SLT;
        3'b011:  w_alu_ctrl = ALU_SLTU;
        3'b100:  w_alu_ctrl = ALU_XOR;
        3'b101:  w_alu_ctrl = w_alt ? ALU_SRA : ALU_SRL;
        3'b110:  w_alu_ctrl = ALU_OR;
        default: w_alu_ctrl = ALU_AND;
      endcase
    end else if (w_is_beq) begin
      w_alu_ctrl = ALU_SUB;
    end
  end

  assign bus.ALUCtrl  = w_alu_ctrl;
  assign bus.ALUSrc   = w_is_i || w_is_lw || w_is_sw;
  assign bus.MemToReg = w_is_lw;
  assign bus.PCSrc    = w_is_beq && bus.Zero;
  assign bus.state    = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  logic w_reg_write, w_load_pc, w_mem_read, w_mem_write, w_mem_timeout, w_illegal_pulse;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_abort_nxt     = r_abort;
    w_reg_write     = 1'b0;
    w_load_pc       = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_timeout   = 1'b0;
    w_illegal_pulse = 1'b0;
    case (r_state)
      S_IF: begin
        w_state_nxt = S_ID;
        w_cnt_nxt   = '0;
        w_abort_nxt = 1'b0;
      end
      S_ID: w_state_nxt = w_illegal ? S_WB : S_EX;
      S_EX: w_state_nxt = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        w_mem_read  = w_is_lw;
        w_mem_write = w_is_sw;
        // an ack arriving on the final allowed cycle still wins over the timeout
        if (bus.dAck) begin
          w_state_nxt = S_WB;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_WB;
          w_cnt_nxt   = '0;
          w_abort_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_WB: begin
        w_load_pc       = 1'b1;
        w_reg_write     = w_is_r || w_is_i || (w_is_lw && !r_abort);
        w_mem_timeout   = r_abort;
        w_illegal_pulse = w_illegal;
        w_state_nxt     = S_IF;
      end
      default: w_state_nxt = S_IF;
    endcase
  end

  assign bus.RegWrite   = w_reg_write;
  assign bus.loadPC     = w_load_pc;
  assign bus.MemRead    = w_mem_read;
  assign bus.MemWrite   = w_mem_write;
  assign bus.memTimeout = w_mem_timeout;
  assign bus.illegal    = w_illegal_pulse;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed bench for riscv_mc_control: walks each instruction class and compares against hand-computed values.
module tb_riscv_mc_control;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_mc_control_if bus();

  riscv_mc_control #(.MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // per-instruction observations
  int          cyc, n_mem, n_rd, n_wr, n_bad;
  logic [63:0] hist;
  logic        wb_rw, wb_lpc, wb_pcs, wb_m2r, wb_asrc, wb_to, wb_ill;
  logic [3:0]  wb_alu;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from IF back to IF; ack_at = MEM cycle on which dAck rises (0 = never),
  // pre = dAck level driven outside MEM.
  task automatic exec(input logic [31:0] ins, input logic zero, input int ack_at, input logic pre);
    bus.instr = ins;
    bus.Zero  = zero;
    bus.dAck  = pre;
    cyc = 0; n_mem = 0; n_rd = 0; n_wr = 0; n_bad = 0;
    hist = 64'(bus.state);
    {wb_rw, wb_lpc, wb_pcs, wb_m2r, wb_asrc, wb_to, wb_ill} = '0;
    wb_alu = '0;
    for (int k = 0; k < 64; k++) begin
      if (bus.state == 3'd3) begin
        n_mem++;
        bus.dAck = (ack_at != 0) && (n_mem == ack_at);
      end else begin
        bus.dAck = pre;
      end
      n_rd += int'(bus.MemRead);
      n_wr += int'(bus.MemWrite);
      if (bus.state != 3'd4 && (bus.RegWrite || bus.loadPC || bus.memTimeout || bus.illegal)) n_bad++;
      if (bus.state != 3'd3 && (bus.MemRead || bus.MemWrite)) n_bad++;
      if (bus.MemRead && bus.MemWrite) n_bad++;
      if (bus.state == 3'd4) begin
        wb_rw = bus.RegWrite; wb_lpc = bus.loadPC; wb_pcs = bus.PCSrc; wb_m2r = bus.MemToReg;
        wb_asrc = bus.ALUSrc; wb_to = bus.memTimeout; wb_ill = bus.illegal; wb_alu = bus.ALUCtrl;
      end
      step();
      cyc++;
      hist = {hist[60:0], bus.state};
      if (bus.state == 3'd0) break;
    end
    check_val("back_to_IF", 64'(bus.state), 64'd0);
    check_val("strobe_outside_state", 64'(n_bad), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.instr = 32'h0000_0013;
    bus.Zero  = 1'b0;
    bus.dAck  = 1'b0;
    #12;
    check_val("rst_state", 64'(bus.state), 64'd0);
    check_val("rst_strobes", 64'({bus.RegWrite, bus.loadPC, bus.MemRead, bus.MemWrite,
                                   bus.memTimeout, bus.illegal}), 64'd0);
    step();
    rst = 1'b0;

    // reset in the middle of an LW memory wait
    bus.instr = 32'h0080_A283;
    step(); step();
    check_val("pre_rst_ex", 64'(bus.state), 64'd2);
    step();
    check_val("pre_rst_mem_read", 64'({bus.state, bus.MemRead}), 64'({3'd3, 1'b1}));
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_state", 64'(bus.state), 64'd0);
    check_val("async_rst_strobes", 64'({bus.RegWrite, bus.loadPC, bus.MemRead, bus.MemWrite}), 64'd0);
    step();
    rst = 1'b0;

    // ADD x3,x1,x2 with Zero=1 to show PCSrc stays 0 for non-branches
    exec(32'h0020_81B3, 1'b1, 0, 1'b0);
    check_val("add_states", hist, 64'({3'd0, 3'd1, 3'd2, 3'd4, 3'd0}));
    check_val("add_cycles", 64'(cyc), 64'd4);
    check_val("add_wb", 64'({wb_rw, wb_lpc, wb_pcs, wb_asrc, wb_alu}), 64'({4'b1100, 4'b0010}));

    exec(32'h4020_81B3, 1'b0, 0, 1'b0);
    check_val("sub_alu", 64'(wb_alu), 64'b0110);

    exec(32'h0020_B1B3, 1'b0, 0, 1'b0);
    check_val("sltu_alu", 64'(wb_alu), 64'b1011);

    // ADDI x1,x0,5
    exec(32'h0050_0093, 1'b0, 0, 1'b0);
    check_val("addi_cycles", 64'(cyc), 64'd4);
    check_val("addi_wb", 64'({wb_rw, wb_lpc, wb_asrc, wb_m2r, wb_alu}), 64'({4'b1110, 4'b0010}));

    exec(32'h4030_D093, 1'b0, 0, 1'b0);
    check_val("srai_alu", 64'(wb_alu), 64'b1010);

    exec(32'h0FF0_C093, 1'b0, 0, 1'b0);
    check_val("xori_alu", 64'(wb_alu), 64'b1101);

    // LW x5,8(x1), dAck on third MEM cycle, dAck held high outside MEM
    exec(32'h0080_A283, 1'b0, 3, 1'b1);
    check_val("lw_mem_cycles", 64'(n_mem), 64'd3);
    check_val("lw_read_cycles", 64'({8'(n_rd), 8'(n_wr)}), 64'({8'd3, 8'd0}));
    check_val("lw_cycles", 64'(cyc), 64'd7);
    check_val("lw_wb", 64'({wb_rw, wb_lpc, wb_m2r, wb_asrc, wb_to, wb_alu}), 64'({5'b11110, 4'b0010}));

    // SW x5,12(x1), immediate ack
    exec(32'h0050_A623, 1'b0, 1, 1'b0);
    check_val("sw_write_cycles", 64'({8'(n_rd), 8'(n_wr)}), 64'({8'd0, 8'd1}));
    check_val("sw_cycles", 64'(cyc), 64'd5);
    check_val("sw_wb", 64'({wb_rw, wb_lpc, wb_m2r, wb_alu}), 64'({3'b010, 4'b0010}));

    // BEQ x1,x2,+8
    exec(32'h0020_8463, 1'b1, 0, 1'b0);
    check_val("beq_taken_wb", 64'({wb_rw, wb_lpc, wb_pcs, wb_asrc, wb_alu}), 64'({4'b0110, 4'b0110}));
    check_val("beq_cycles", 64'(cyc), 64'd4);
    exec(32'h0020_8463, 1'b0, 0, 1'b0);
    check_val("beq_not_taken_wb", 64'({wb_rw, wb_lpc, wb_pcs}), 64'(3'b010));

    // LW timeout
    exec(32'h0080_A283, 1'b0, 0, 1'b0);
    check_val("lw_to_mem_cycles", 64'(n_mem), 64'd16);
    check_val("lw_to_cycles", 64'(cyc), 64'd20);
    check_val("lw_to_wb", 64'({wb_to, wb_rw, wb_lpc}), 64'(3'b101));

    // ack on the last allowed MEM cycle counts as success
    exec(32'h0080_A283, 1'b0, 16, 1'b0);
    check_val("lw_edge_mem_cycles", 64'(n_mem), 64'd16);
    check_val("lw_edge_wb", 64'({wb_to, wb_rw, wb_lpc}), 64'(3'b011));

    // illegal opcode 0x7F and LB (unsupported funct3)
    exec(32'h0000_007F, 1'b0, 0, 1'b0);
    check_val("ill_states", hist, 64'({3'd0, 3'd1, 3'd4, 3'd0}));
    check_val("ill_cycles", 64'(cyc), 64'd3);
    check_val("ill_wb", 64'({wb_ill, wb_rw, wb_lpc, wb_alu}), 64'({3'b101, 4'b0010}));
    exec(32'h0000_8283, 1'b0, 1, 1'b0);
    check_val("lb_illegal", 64'({wb_ill, wb_rw, 8'(n_rd), 8'(cyc)}), 64'({2'b10, 8'd0, 8'd3}));

    // following instruction after all the above starts cleanly
    exec(32'h0020_81B3, 1'b0, 0, 1'b0);
    check_val("final_add_wb", 64'({wb_rw, wb_lpc, wb_to, wb_ill, 8'(cyc)}), 64'({4'b1100, 8'd4}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
